// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
// The fetch unit is the master; memory/decode (or a bench) sit on the slave side.
interface instr_fetch_if #(
    parameter int N  = 16,
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [N-1:0]  imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          issue_valid;
    logic          issue_ready;
    logic [N-1:0]  issue_instr;
    logic [2:0]    issue_op;
    logic [AW-1:0] issue_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output issue_valid,
        input  issue_ready,
        output issue_instr, issue_op, issue_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  issue_valid,
        output issue_ready,
        input  issue_instr, issue_op, issue_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding imem requests, 2-entry issue buffer,
// redirect with flush. All outputs come straight from registers.
module instr_fetch #(
    parameter int            N        = 16,
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_fetch_if.master     bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [1:0]    count_q, count_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;
    logic [AW-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;

    logic pop_s;
    logic push_s;
    logic push_slot1_s;

    assign pop_s  = valid_q & bus.issue_ready;
    // An ack is only kept when it answers a live FETCH and no redirect overrides it.
    assign push_s = (state_q == ST_FETCH) & bus.imem_ack & ~bus.redirect;
    assign push_slot1_s = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop_s);

    // PC and occupancy next-state
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc;
            count_d = 2'd0;
        end else begin
            count_d = count_q - {1'b0, pop_s} + {1'b0, push_s};
            if (push_s) begin
                pc_d = pc_q + AW'(1);
            end else begin
                pc_d = pc_q;
            end
        end
    end

    // Buffer entries: entry 0 is the head, entry 1 shifts forward on a pop
    always_comb begin
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;
        if (!bus.redirect) begin
            if (pop_s && (count_q == 2'd2)) begin
                e0_instr_d = e1_instr_q;
                e0_pc_d    = e1_pc_q;
            end else begin
                e0_instr_d = e0_instr_q;
                e0_pc_d    = e0_pc_q;
            end
            if (push_s && push_slot1_s) begin
                e1_instr_d = bus.imem_rdata;
                e1_pc_d    = pc_q;
            end else if (push_s) begin
                e0_instr_d = bus.imem_rdata;
                e0_pc_d    = pc_q;
            end else begin
                e1_instr_d = e1_instr_q;
            end
        end else begin
            e0_instr_d = e0_instr_q;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.redirect || (count_d < 2'd2)) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.redirect) begin
                    state_d = bus.imem_ack ? ST_FETCH : ST_DISCARD;
                end else if (bus.imem_ack) begin
                    state_d = (count_d < 2'd2) ? ST_FETCH : ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (bus.imem_ack) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: a DISCARD keeps presenting the stale address until its ack
    always_comb begin
        req_d   = (state_d != ST_IDLE);
        valid_d = (count_d != 2'd0);
        if (state_d == ST_FETCH) begin
            addr_d = pc_d;
        end else begin
            addr_d = addr_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            e0_instr_q <= '0;
            e0_pc_q    <= '0;
            e1_instr_q <= '0;
            e1_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.issue_valid = valid_q;
    assign bus.issue_instr = e0_instr_q;
    assign bus.issue_op    = e0_instr_q[N-1:N-3];
    assign bus.issue_pc    = e0_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder with variable latency, an issue-stream
// scoreboard fed from an address-sequence model, and directed redirect/reset cases.
module tb_instr_fetch;
    localparam int N  = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.N(N), .AW(AW)) bus ();

    instr_fetch #(.N(N), .AW(AW), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 0;
    bit lat_rand = 1'b0;
    int ack_cnt = 0;
    int hs_cnt = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory word k: opcode k[2:0], then a scrambled tag and the address itself.
    function automatic logic [15:0] mem_word(logic [7:0] a);
        return {a[2:0], a[7:3] ^ 5'h15, a};
    endfunction

    // Instruction memory responder, driven 1 time unit after each rising edge
    initial begin
        int waitc;
        int cur_lat;
        bit pend;
        logic [7:0] pend_addr;
        waitc = 0; cur_lat = 0; pend = 1'b0; pend_addr = 8'h00;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                bus.imem_ack = 1'b0;
                waitc = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("req_hold", bus.imem_req, 1);
                    check("addr_hold", bus.imem_addr, pend_addr);
                end
                bus.imem_ack = 1'b0;
                pend = 1'b0;
                if (bus.imem_req) begin
                    if (waitc == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
                    if (waitc >= cur_lat) begin
                        bus.imem_ack = 1'b1;
                        bus.imem_rdata = mem_word(bus.imem_addr);
                        waitc = 0;
                    end else begin
                        waitc++;
                        pend = 1'b1;
                        pend_addr = bus.imem_addr;
                    end
                end else begin
                    waitc = 0;
                end
            end
        end
    end

    // Scoreboard: expected issue stream is consecutive addresses from the last restart
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;
    exp_t exp_q[$];
    logic [7:0] nxt_pc = 8'h00;

    initial begin
        bit prev_redir;
        exp_t e;
        prev_redir = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                nxt_pc = 8'h00;
                prev_redir = 1'b0;
            end else begin
                if (prev_redir) check("valid_after_redirect", bus.issue_valid, 0);
                if (bus.imem_req && bus.imem_ack) ack_cnt++;
                if (bus.issue_valid && bus.issue_ready) begin
                    e = exp_q.pop_front();
                    check("issue_pc", bus.issue_pc, e.pc);
                    check("issue_instr", bus.issue_instr, e.instr);
                    check("issue_op", bus.issue_op, e.instr[15:13]);
                    hs_cnt++;
                end
                if (bus.redirect) begin
                    exp_q.delete();
                    nxt_pc = bus.redirect_pc;
                end
                prev_redir = bus.redirect;
            end
            while (exp_q.size() < 4) begin
                e.pc = nxt_pc;
                e.instr = mem_word(nxt_pc);
                exp_q.push_back(e);
                nxt_pc++;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic redirect_to(logic [7:0] pc);
        bus.redirect = 1'b1;
        bus.redirect_pc = pc;
        cyc(1);
        bus.redirect = 1'b0;
    endtask

    initial begin
        int t;
        int a0;
        int h0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.issue_ready = 1'b1;
        #2 reset_n = 1'b0;
        cyc(2);
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 8'h00);
        check("rst_valid", bus.issue_valid, 0);
        check("rst_instr", bus.issue_instr, 0);
        check("rst_op", bus.issue_op, 0);
        check("rst_pc", bus.issue_pc, 0);

        // Fill with ack every cycle
        reset_n = 1'b1;
        cyc(1);
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 8'h00);
        cyc(3);
        h0 = hs_cnt;
        cyc(10);
        check("throughput", hs_cnt - h0, 10);

        // Backpressure
        bus.issue_ready = 1'b0;
        cyc(6);
        check("bp_req_low", bus.imem_req, 0);
        check("bp_valid", bus.issue_valid, 1);
        a0 = ack_cnt;
        cyc(5);
        check("bp_no_acks", ack_cnt - a0, 0);
        redirect_to(8'h20);
        a0 = ack_cnt;
        cyc(8);
        check("bp_two_acks", ack_cnt - a0, 2);
        check("bp_req_low2", bus.imem_req, 0);
        bus.issue_ready = 1'b1;
        cyc(1);
        bus.issue_ready = 1'b0;
        a0 = ack_cnt;
        cyc(6);
        check("bp_one_refill", ack_cnt - a0, 1);
        bus.issue_ready = 1'b1;
        cyc(6);

        // Redirect while a slow request is pending
        lat = 3;
        redirect_to(8'h05);
        t = 0;
        while (!(bus.imem_req && bus.imem_addr == 8'h05 && !bus.imem_ack) && t < 40) begin
            cyc(1); t++;
        end
        check("wait_addr05", int'(t < 40), 1);
        redirect_to(8'h40);
        check("stale_req", bus.imem_req, 1);
        check("stale_addr", bus.imem_addr, 8'h05);
        t = 0;
        while (!bus.imem_ack && t < 40) begin
            cyc(1); t++;
        end
        check("wait_stale_ack", int'(t < 40), 1);
        cyc(1);
        check("after_stale_req", bus.imem_req, 1);
        check("after_stale_addr", bus.imem_addr, 8'h40);
        cyc(12);

        // Redirect coincident with an ack
        lat = 2;
        redirect_to(8'h03);
        t = 0;
        while (!(bus.imem_req && bus.imem_addr == 8'h03 && bus.imem_ack) && t < 40) begin
            cyc(1); t++;
        end
        check("wait_ack03", int'(t < 40), 1);
        redirect_to(8'h10);
        check("coinc_valid", bus.issue_valid, 0);
        check("coinc_req", bus.imem_req, 1);
        check("coinc_addr", bus.imem_addr, 8'h10);
        cyc(10);

        // Address wrap
        lat_rand = 1'b1;
        redirect_to(8'hFE);
        h0 = hs_cnt;
        t = 0;
        while ((hs_cnt - h0) < 4 && t < 60) begin
            cyc(1); t++;
        end
        check("wrap_issued", int'(t < 60), 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.issue_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) redirect_to(8'($urandom_range(0, 255)));
            else cyc(1);
        end

        // Reset in the middle of a request with one buffered entry
        lat_rand = 1'b0;
        lat = 3;
        bus.issue_ready = 1'b0;
        redirect_to(8'h30);
        t = 0;
        while (!(bus.issue_valid && bus.imem_req && !bus.imem_ack) && t < 40) begin
            cyc(1); t++;
        end
        check("wait_mid_req", int'(t < 40), 1);
        reset_n = 1'b0;
        #1;
        check("async_req", bus.imem_req, 0);
        check("async_valid", bus.issue_valid, 0);
        check("async_op", bus.issue_op, 0);
        cyc(2);
        lat = 0;
        bus.issue_ready = 1'b1;
        reset_n = 1'b1;
        cyc(1);
        check("restart_req", bus.imem_req, 1);
        check("restart_addr", bus.imem_addr, 8'h00);
        cyc(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and issue unit that produces the instruction stream consumed by `maindec`. It keeps a word-addressed program counter and issues single-outstanding read requests to instruction memory over a req/ack interface. Fetched words go into a 2-entry buffer and are presented to the decode stage with a valid/ready handshake. The unit exposes the opcode field directly as `issue_op`, which drives `maindec.op`, and it supports branch/jump redirects that flush the buffer.

## Interface
- `N`, 16, instruction width in bits; the opcode is `instr[N-1:N-3]`.
- `AW`, 8, instruction address width; addresses are word addresses.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  AW  read address; held stable while `imem_req` is high.
- `imem_ack`  in  1  read complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  N  instruction word.
- `redirect`  in  1  one-cycle pulse requesting a fetch restart.
- `redirect_pc`  in  AW  new PC, sampled when `redirect` is high.
- `issue_valid`  out  1  the buffer head holds an instruction.
- `issue_ready`  in  1  the decode stage accepts the head entry.
- `issue_instr`  out  N  head instruction.
- `issue_op`  out  3  `issue_instr[N-1:N-3]`; connects to `maindec.op`.
- `issue_pc`  out  AW  address of the head instruction.

## Operation
- **Buffer:** 2-entry FIFO of {instr, pc}, with `count` from 0 to 2. The head entry drives the `issue_*` outputs. Pop occurs when `issue_valid && issue_ready`; push occurs when an ack is accepted (not discarded).
- **FSM states:**
  - **IDLE:** `imem_req`=0.
  - **FETCH:** `imem_req`=1 and `imem_addr`=`pc`.
  - **DISCARD:** `imem_req`=1 and `imem_addr`=the stale address, waiting to drop a response.
- **Request rule:** once `imem_req` is raised, it and `imem_addr` must stay constant until `imem_ack`. At most one request is outstanding at any time.
- **IDLE → FETCH** when the post-update `count` is below 2.
- **FETCH with `imem_ack`:**
  - Push {`imem_rdata`, `pc`} and set `pc` ← `pc`+1.
  - Stay in FETCH if the post-update `count` is below 2 (the next address is presented the following cycle). Otherwise go to IDLE.
- **FETCH without ack:** hold the request.
- **Redirect** (highest priority, evaluated every cycle):
  - Flush the buffer (`count`←0) and set `pc` ← `redirect_pc`.
  - IDLE → FETCH.
  - FETCH with ack in the same cycle: the ack data is dropped and the state stays FETCH with the new `pc`.
  - FETCH without ack → DISCARD.
  - DISCARD: stays DISCARD, and only `pc` is updated.
- **DISCARD with ack:** drop the data and go to FETCH at the current `pc`.
- **Pop concurrent with redirect:** the handshake counts as completed for the consumer. The flush discards everything else.
- **Pop concurrent with push:** `count` is unchanged, and ordering is preserved.
- **PC arithmetic:** modulo 2^AW, so `pc` wraps from 2^AW−1 to 0 with no flag.
- **Reset (asynchronous, any time including mid-request):**
  - State goes to IDLE, `count`=0 and `pc`=`RESET_PC`.
  - Any pending ack is ignored.
  - Output values: `imem_req`=0, `imem_addr`=`RESET_PC`, `issue_valid`=0, `issue_instr`=0, `issue_op`=0, `issue_pc`=0.

## Timing
- First `imem_req` is asserted in the first rising-edge cycle after `reset_n` deasserts (IDLE→FETCH on that edge).
- Ack to `issue_valid`: 1 cycle (registered push).
- Throughput: with `imem_ack` tied high and `issue_ready` high, one instruction is issued per cycle after a 2-cycle fill.
- Redirect to new-address request:
  - 1 cycle from IDLE or FETCH.
  - In DISCARD, 1 cycle after the stale ack.
- Redirect to `issue_valid`=0: the next cycle.
- All outputs are registered. No combinational path from `issue_ready` or `imem_ack` to any output.

## Test plan
- **Reset and fill:** `reset_n` low then high, ack immediately, memory word k holds op=k[2:0]. Expected:
  - `imem_addr` 0,1,2…
  - `issue_op` sequence 0,1,2,…,7, then 0 again, with `issue_pc` matching.
  - `maindec` outputs change each cycle.
- **Backpressure:** hold `issue_ready`=0. Expected:
  - `imem_req` drops after exactly 2 accepted acks, and `count`=2.
  - Raising `issue_ready` for 1 cycle yields exactly one new request.
  - No instruction is lost or duplicated.
- **Redirect with a slow ack:** ack latency 3 cycles, redirect to 0x40 while `imem_addr`=0x05 is pending. Expected:
  - `imem_addr` stays 0x05 until its ack.
  - That data is never issued.
  - The next request is 0x40, and the first issued `issue_pc`=0x40.
- **Redirect and ack in the same cycle:** redirect to 0x10 coincident with the ack for 0x03. Expected:
  - 0x03 is dropped and the next request is 0x10.
  - `issue_valid` is 0 the cycle after.
- **Wrap:** redirect to 0xFE. Expected: fetched and issued pc sequence 0xFE, 0xFF, 0x00, 0x01.
- **Mid-request reset:** assert `reset_n`=0 while `imem_req`=1 and `count`=1. Expected:
  - `imem_req`, `issue_valid` and `issue_op` go to 0 immediately (asynchronous).
  - After release, fetch restarts at `RESET_PC`.
